rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Sits directly downstream of the rv32i core.
- Consumes the core's instruction port (mem_i_*) and data port (mem_d_*) and merges them onto one single-port memory bus with a req/ready handshake.
- Latches strobed requests, arbitrates with data-over-instruction priority, and drives the per-port busy flags the core stalls on.

Parameters:
- ADDR_W, 32, width of addresses on both core ports and the bus.
- TIMEOUT_CYCLES, 255, bus cycles before a stalled transfer is aborted (used only with the optional feature).

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_i_addr  in  ADDR_W  fetch address, sampled with mem_i_rstrb
- mem_i_rstrb  in  1  fetch request strobe
- mem_i_rdata  out  32  fetched word, registered
- mem_i_rbusy  out  1  fetch in progress
- mem_d_addr  in  ADDR_W  data address
- mem_d_wdata  in  32  store data
- mem_d_wmask  in  4  byte enables for stores
- mem_d_wstrb  in  1  store strobe
- mem_d_rstrb  in  1  load strobe
- mem_d_rdata  out  32  loaded word, registered
- mem_d_rbusy  out  1  load in progress
- mem_d_wbusy  out  1  store in progress
- bus_req  out  1  transfer request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  transfer address
- bus_wdata  out  32  write data
- bus_wmask  out  4  write byte enables; 4'b0000 on reads
- bus_ready  in  1  transfer complete this cycle
- bus_rdata  in  32  read data, valid with bus_ready on reads
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n low):
  - Outputs forced immediately: all busy flags 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_wmask 0, rdata outputs 0, bus_err 0.
  - Pending flags cleared; FSM to IDLE.
  - An in-flight transfer is dropped without waiting for bus_ready.
- Request capture:
  - A strobe on a port whose busy flag is 0 latches address, data and mask into that port's pending slot.
  - That port's busy flag goes to 1 on the next edge.
  - A strobe while the port's busy flag is 1 is ignored.
- Data-port strobe conflict: if mem_d_wstrb and mem_d_rstrb are both 1 in one cycle, the write is captured, the read is dropped, and only mem_d_wbusy is raised.
- FSM states: IDLE, I_XFER, D_XFER.
  - IDLE: D pending -> D_XFER; else I pending -> I_XFER.
  - Transition edge: bus_req=1 and bus fields are driven from the pending slot.
- Bus handshake:
  - bus_req and all bus fields are held stable until bus_ready is sampled 1.
  - bus_ready while bus_req=0 is ignored.
- Completion edge:
  - On reads, bus_rdata is registered into the owning port's rdata; that port's busy goes to 0 and its pending slot clears.
  - If the other port is pending, the FSM moves directly to its XFER state: bus_req stays 1 and the fields switch. Otherwise the FSM returns to IDLE and bus_req goes to 0.
- Latency, uncontended: strobe at cycle N -> bus_req at N+1. With bus_ready at cycle M (M >= N+1), rdata is valid and busy is 0 from M+1.
- Priority:
  - A simultaneous I and D strobe serves D first.
  - A D strobe arriving during an I transfer waits for that transfer to finish; there is no preemption.
- Held data: rdata on each port holds its last value until that port's next read completes. Write completion leaves rdata unchanged.

Optional Feature:
- Macro: RV32I_MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to an XFER state and increments each cycle bus_ready is 0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer aborts: bus_req goes to 0, the owning port's busy goes to 0, read rdata is set to 32'h00000000, and bus_err is set sticky until reset.
  - The FSM then proceeds as at a normal completion.
- Undefined: no counter; transfers wait indefinitely; bus_err is tied 0.

Test Plan:
- Fetch, no contention: mem_i_rstrb=1 with mem_i_addr=0x100 at cycle 0; bus_ready=1 with bus_rdata=0x00000013 at cycle 3 -> bus_req=1, bus_we=0, bus_addr=0x100 over cycles 1-3; mem_i_rdata=0x13 and mem_i_rbusy=0 at cycle 4.
- Simultaneous requests: mem_i_rstrb (addr 0x200) and mem_d_wstrb (addr 0x8000, wdata 0xCAFEF00D, wmask 4'b0011) in one cycle -> write issued first with bus_we=1 and bus_wmask=0011; the read to 0x200 follows with bus_req never dropping; mem_d_rdata unchanged.
- Data-port conflict: mem_d_wstrb and mem_d_rstrb both 1 -> exactly one bus write; mem_d_rbusy stays 0.
- Strobe while busy: repeat mem_i_rstrb with addr 0x300 while mem_i_rbusy=1 -> no second transfer issued; the original address completes.
- Reset mid-transfer: rst_n low while bus_req=1 -> bus_req and all busy flags go to 0 with no clock edge; after release, a new fetch completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=4): D read with bus_ready held 0 -> abort after 4 cycles; mem_d_rdata=0 and bus_err=1; a following fetch still completes.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Core-port and memory-bus signal bundle for rv32i_mem_arbiter.
// The master modport is the arbiter's view; slave is the core/memory side.
interface rv32i_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_i_addr;
    logic              mem_i_rstrb;
    logic [31:0]       mem_i_rdata;
    logic              mem_i_rbusy;

    logic [ADDR_W-1:0] mem_d_addr;
    logic [31:0]       mem_d_wdata;
    logic [3:0]        mem_d_wmask;
    logic              mem_d_wstrb;
    logic              mem_d_rstrb;
    logic [31:0]       mem_d_rdata;
    logic              mem_d_rbusy;
    logic              mem_d_wbusy;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wmask;
    logic              bus_ready;
    logic [31:0]       bus_rdata;
    logic              bus_err;

    modport master (
        input  mem_i_addr, mem_i_rstrb,
        input  mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb,
        input  bus_ready, bus_rdata,
        output mem_i_rdata, mem_i_rbusy,
        output mem_d_rdata, mem_d_rbusy, mem_d_wbusy,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, bus_err
    );

    modport slave (
        output mem_i_addr, mem_i_rstrb,
        output mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb,
        output bus_ready, bus_rdata,
        input  mem_i_rdata, mem_i_rbusy,
        input  mem_d_rdata, mem_d_rbusy, mem_d_wbusy,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, bus_err
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Merges the rv32i fetch and data ports onto one req/ready memory bus, data first.
// Optional transfer timeout enabled by defining RV32I_MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no transfer on the bus, bus_req low
// S_IXFER | fetch slot owns the bus
// S_DXFER | data slot (load or store) owns the bus
module rv32i_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    rv32i_mem_arbiter_if.master mif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IXFER = 2'd1;
    localparam logic [1:0] S_DXFER = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              pend_i_q, pend_i_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic              pend_d_q, pend_d_d;
    logic              d_we_q, d_we_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [31:0]       d_wdata_q, d_wdata_d;
    logic [3:0]        d_wmask_q, d_wmask_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wmask_q, bus_wmask_d;
    logic              done;
    logic              in_xfer;

`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             abort;
`endif

    always_comb begin
        state_d     = state_q;
        pend_i_d    = pend_i_q;
        i_addr_d    = i_addr_q;
        pend_d_d    = pend_d_q;
        d_we_d      = d_we_q;
        d_addr_d    = d_addr_q;
        d_wdata_d   = d_wdata_q;
        d_wmask_d   = d_wmask_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        in_xfer     = (state_q == S_IXFER) || (state_q == S_DXFER);
        done        = in_xfer && mif.bus_ready;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
        tmo_d = tmo_q;
        err_d = err_q;
        abort = in_xfer && !mif.bus_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        if (in_xfer && !mif.bus_ready) tmo_d = tmo_q + 1'b1;
        if (abort) begin
            done  = 1'b1;
            err_d = 1'b1;
        end
`endif

        // Capture into the _d slot first so a fresh strobe can be issued on the same edge.
        if (mif.mem_i_rstrb && !pend_i_q) begin
            pend_i_d = 1'b1;
            i_addr_d = mif.mem_i_addr;
        end
        if ((mif.mem_d_wstrb || mif.mem_d_rstrb) && !pend_d_q) begin
            pend_d_d  = 1'b1;
            d_we_d    = mif.mem_d_wstrb;
            d_addr_d  = mif.mem_d_addr;
            d_wdata_d = mif.mem_d_wdata;
            d_wmask_d = mif.mem_d_wmask;
        end

        if (done) begin
            if (state_q == S_IXFER) begin
                pend_i_d  = 1'b0;
                i_rdata_d = mif.bus_ready ? mif.bus_rdata : 32'h0;
            end else begin
                pend_d_d = 1'b0;
                if (!d_we_q) d_rdata_d = mif.bus_ready ? mif.bus_rdata : 32'h0;
            end
        end

        if (state_q == S_IDLE || done) begin
            if (pend_d_d) begin
                state_d     = S_DXFER;
                bus_req_d   = 1'b1;
                bus_we_d    = d_we_d;
                bus_addr_d  = d_addr_d;
                bus_wdata_d = d_we_d ? d_wdata_d : 32'h0;
                bus_wmask_d = d_we_d ? d_wmask_d : 4'b0000;
            end else if (pend_i_d) begin
                state_d     = S_IXFER;
                bus_req_d   = 1'b1;
                bus_we_d    = 1'b0;
                bus_addr_d  = i_addr_d;
                bus_wdata_d = 32'h0;
                bus_wmask_d = 4'b0000;
            end else begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
            tmo_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_i_q    <= 1'b0;
            i_addr_q    <= '0;
            pend_d_q    <= 1'b0;
            d_we_q      <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= 32'h0;
            d_wmask_q   <= 4'b0000;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'h0;
            bus_wmask_q <= 4'b0000;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_i_q    <= pend_i_d;
            i_addr_q    <= i_addr_d;
            pend_d_q    <= pend_d_d;
            d_we_q      <= d_we_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_wmask_q   <= d_wmask_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    // Busy flags are exactly the pending slots, so reset clears them without an edge.
    assign mif.mem_i_rbusy = pend_i_q;
    assign mif.mem_d_rbusy = pend_d_q & ~d_we_q;
    assign mif.mem_d_wbusy = pend_d_q & d_we_q;
    assign mif.mem_i_rdata = i_rdata_q;
    assign mif.mem_d_rdata = d_rdata_q;
    assign mif.bus_req     = bus_req_q;
    assign mif.bus_we      = bus_we_q;
    assign mif.bus_addr    = bus_addr_q;
    assign mif.bus_wdata   = bus_wdata_q;
    assign mif.bus_wmask   = bus_wmask_q;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    assign mif.bus_err     = err_q;
`else
    assign mif.bus_err     = 1'b0;
`endif
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: per-scenario tasks plus a bus-transaction scoreboard.
module tb_rv32i_mem_arbiter;
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    txn_t exp_q[$];
    bit   auto_en;
    int   lat;
    int   cnt;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;

    rv32i_mem_arbiter_if #(.ADDR_W(32)) mif ();

    rv32i_mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h1357_9BDF);
    endfunction

    // Memory responder: asserts bus_ready lat cycles after a transfer appears.
    initial begin
        mif.bus_ready = 1'b0;
        mif.bus_rdata = 32'h0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mif.bus_ready) cnt = 0;
            if (auto_en && mif.bus_req) begin
                if (cnt == lat) begin
                    mif.bus_ready = 1'b1;
                    mif.bus_rdata = rd_fn(mif.bus_addr);
                end else begin
                    mif.bus_ready = 1'b0;
                end
                cnt++;
            end else begin
                mif.bus_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Scoreboard: every accepted bus transfer must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && mif.bus_req && mif.bus_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_txn: unexpected transfer we=%0b addr=%h", mif.bus_we, mif.bus_addr);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                if (mif.bus_we !== e.we || mif.bus_addr !== e.addr || mif.bus_wmask !== e.wmask ||
                    (e.we && mif.bus_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL bus_txn: got we=%0b addr=%h wdata=%h wmask=%b, want we=%0b addr=%h wdata=%h wmask=%b",
                             mif.bus_we, mif.bus_addr, mif.bus_wdata, mif.bus_wmask,
                             e.we, e.addr, e.wdata, e.wmask);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((mif.bus_req || mif.mem_i_rbusy || mif.mem_d_rbusy || mif.mem_d_wbusy) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({mif.bus_req, mif.bus_we, mif.mem_i_rbusy, mif.mem_d_rbusy, mif.mem_d_wbusy, mif.bus_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {mif.bus_req, mif.bus_we, mif.mem_i_rbusy, mif.mem_d_rbusy, mif.mem_d_wbusy, mif.bus_err});
        end
        checks++;
        if (mif.bus_addr !== 32'h0 || mif.bus_wdata !== 32'h0 || mif.bus_wmask !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h wmask=%b, want zeros", mif.bus_addr, mif.bus_wdata, mif.bus_wmask);
        end
        checks++;
        if (mif.mem_i_rdata !== 32'h0 || mif.mem_d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got i=%h d=%h, want 0", mif.mem_i_rdata, mif.mem_d_rdata);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        mif.mem_i_addr  = 32'h100;
        mif.mem_i_rstrb = 1'b1;
        exp_q.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
        tick();
        mif.mem_i_rstrb = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (mif.bus_req !== 1'b1 || mif.bus_we !== 1'b0 || mif.bus_addr !== 32'h100 || mif.mem_i_rbusy !== 1'b1) begin
                errors++;
                $display("FAIL fetch_cycle%0d: got req=%0b we=%0b addr=%h busy=%0b, want 1 0 00000100 1",
                         c, mif.bus_req, mif.bus_we, mif.bus_addr, mif.mem_i_rbusy);
            end
            tick();
        end
        exp_i_rdata = 32'h13;
        checks++;
        if (mif.mem_i_rdata !== exp_i_rdata || mif.mem_i_rbusy !== 1'b0 || mif.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: got rdata=%h busy=%0b req=%0b, want 00000013 0 0",
                     mif.mem_i_rdata, mif.mem_i_rbusy, mif.bus_req);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        mif.mem_i_addr  = 32'h200;
        mif.mem_i_rstrb = 1'b1;
        mif.mem_d_addr  = 32'h8000;
        mif.mem_d_wdata = 32'hCAFE_F00D;
        mif.mem_d_wmask = 4'b0011;
        mif.mem_d_wstrb = 1'b1;
        exp_q.push_back('{1'b1, 32'h8000, 32'hCAFE_F00D, 4'b0011});
        exp_q.push_back('{1'b0, 32'h200, 32'h0, 4'h0});
        tick();
        mif.mem_i_rstrb = 1'b0;
        mif.mem_d_wstrb = 1'b0;
        checks++;
        if (mif.bus_we !== 1'b1 || mif.bus_addr !== 32'h8000 || mif.bus_wmask !== 4'b0011 || mif.mem_d_wbusy !== 1'b1) begin
            errors++;
            $display("FAIL simul_first: got we=%0b addr=%h wmask=%b wbusy=%0b, want 1 00008000 0011 1",
                     mif.bus_we, mif.bus_addr, mif.bus_wmask, mif.mem_d_wbusy);
        end
        while (mif.mem_i_rbusy && n < 30) begin
            checks++;
            if (mif.bus_req !== 1'b1) begin
                errors++;
                $display("FAIL simul_req_held: got bus_req=%0b at cycle %0d, want 1", mif.bus_req, n);
            end
            tick();
            n++;
        end
        wait_idle("simul");
        exp_i_rdata = rd_fn(32'h200);
        checks++;
        if (mif.mem_i_rdata !== exp_i_rdata || mif.mem_d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL simul_rdata: got i=%h d=%h, want i=%h d=%h",
                     mif.mem_i_rdata, mif.mem_d_rdata, exp_i_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_conflict();
        int n = 0;
        mif.mem_d_addr  = 32'h40;
        mif.mem_d_wdata = 32'h1122_3344;
        mif.mem_d_wmask = 4'b1111;
        mif.mem_d_wstrb = 1'b1;
        mif.mem_d_rstrb = 1'b1;
        exp_q.push_back('{1'b1, 32'h40, 32'h1122_3344, 4'b1111});
        tick();
        mif.mem_d_wstrb = 1'b0;
        mif.mem_d_rstrb = 1'b0;
        while (mif.mem_d_wbusy && n < 30) begin
            checks++;
            if (mif.mem_d_rbusy !== 1'b0) begin
                errors++;
                $display("FAIL conflict_rbusy: got %0b, want 0", mif.mem_d_rbusy);
            end
            tick();
            n++;
        end
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (n == 0 || mif.bus_req !== 1'b0 || mif.mem_d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL conflict_after: got wbusy_cycles=%0d req=%0b d_rdata=%h, want >0 0 %h",
                     n, mif.bus_req, mif.mem_d_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_busy_strobe();
        mif.mem_i_addr  = 32'h280;
        mif.mem_i_rstrb = 1'b1;
        exp_q.push_back('{1'b0, 32'h280, 32'h0, 4'h0});
        tick();
        mif.mem_i_addr = 32'h300;
        tick();
        mif.mem_i_rstrb = 1'b0;
        wait_idle("busy_strobe");
        for (int c = 0; c < 3; c++) tick();
        exp_i_rdata = rd_fn(32'h280);
        checks++;
        if (mif.mem_i_rdata !== exp_i_rdata || mif.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL busy_strobe: got rdata=%h req=%0b, want %h 0", mif.mem_i_rdata, mif.bus_req, exp_i_rdata);
        end
    endtask

    task automatic test_back_to_back();
        mif.mem_i_addr  = 32'h400;
        mif.mem_i_rstrb = 1'b1;
        exp_q.push_back('{1'b0, 32'h400, 32'h0, 4'h0});
        exp_q.push_back('{1'b0, 32'h404, 32'h0, 4'h0});
        tick();
        mif.mem_i_rstrb = 1'b0;
        mif.mem_d_addr  = 32'h404;
        mif.mem_d_rstrb = 1'b1;
        tick();
        mif.mem_d_rstrb = 1'b0;
        checks++;
        if (mif.bus_addr !== 32'h400 || mif.mem_d_rbusy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_preempt: got addr=%h rbusy=%0b, want 00000400 1", mif.bus_addr, mif.mem_d_rbusy);
        end
        wait_idle("b2b");
        exp_i_rdata = rd_fn(32'h400);
        exp_d_rdata = rd_fn(32'h404);
        checks++;
        if (mif.mem_i_rdata !== exp_i_rdata || mif.mem_d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL b2b_rdata: got i=%h d=%h, want i=%h d=%h",
                     mif.mem_i_rdata, mif.mem_d_rdata, exp_i_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        mif.mem_i_addr  = 32'h480;
        mif.mem_i_rstrb = 1'b1;
        tick();
        mif.mem_i_rstrb = 1'b0;
        tick();
        checks++;
        if (mif.bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got bus_req=%0b, want 1", mif.bus_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mif.bus_req, mif.mem_i_rbusy, mif.mem_d_rbusy, mif.mem_d_wbusy} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_async: got req/busy=%b, want 0000",
                     {mif.bus_req, mif.mem_i_rbusy, mif.mem_d_rbusy, mif.mem_d_wbusy});
        end
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        tick();
        rst_n = 1'b1;
        auto_en = 1'b1;
        tick();
        mif.mem_i_addr  = 32'h500;
        mif.mem_i_rstrb = 1'b1;
        exp_q.push_back('{1'b0, 32'h500, 32'h0, 4'h0});
        tick();
        mif.mem_i_rstrb = 1'b0;
        wait_idle("rstmid_after");
        exp_i_rdata = rd_fn(32'h500);
        checks++;
        if (mif.mem_i_rdata !== exp_i_rdata) begin
            errors++;
            $display("FAIL rstmid_fetch: got rdata=%h, want %h", mif.mem_i_rdata, exp_i_rdata);
        end
    endtask

`ifdef RV32I_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        mif.mem_d_addr  = 32'h404;
        mif.mem_d_rstrb = 1'b1;
        exp_q.push_back('{1'b0, 32'h404, 32'h0, 4'h0});
        tick();
        mif.mem_d_rstrb = 1'b0;
        wait_idle("tmo_prime");
        exp_d_rdata = rd_fn(32'h404);
        auto_en = 1'b0;
        mif.mem_d_addr  = 32'h900;
        mif.mem_d_rstrb = 1'b1;
        tick();
        mif.mem_d_rstrb = 1'b0;
        while (mif.bus_req && n < 20) begin
            tick();
            n++;
        end
        exp_d_rdata = 32'h0;
        checks++;
        if (n !== 4 || mif.mem_d_rbusy !== 1'b0 || mif.mem_d_rdata !== exp_d_rdata || mif.bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: got req_cycles=%0d rbusy=%0b rdata=%h err=%0b, want 4 0 00000000 1",
                     n, mif.mem_d_rbusy, mif.mem_d_rdata, mif.bus_err);
        end
        auto_en = 1'b1;
        mif.mem_i_addr  = 32'h600;
        mif.mem_i_rstrb = 1'b1;
        exp_q.push_back('{1'b0, 32'h600, 32'h0, 4'h0});
        tick();
        mif.mem_i_rstrb = 1'b0;
        wait_idle("timeout_after");
        exp_i_rdata = rd_fn(32'h600);
        checks++;
        if (mif.mem_i_rdata !== exp_i_rdata || mif.bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: got rdata=%h err=%0b, want %h 1", mif.mem_i_rdata, mif.bus_err, exp_i_rdata);
        end
    endtask
`else
    task automatic test_no_timeout();
        checks++;
        if (mif.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL bus_err_tied: got %0b, want 0", mif.bus_err);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        auto_en = 1'b1;
        lat = 2;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        rst_n = 1'b0;
        mif.mem_i_addr  = 32'h0;
        mif.mem_i_rstrb = 1'b0;
        mif.mem_d_addr  = 32'h0;
        mif.mem_d_wdata = 32'h0;
        mif.mem_d_wmask = 4'h0;
        mif.mem_d_wstrb = 1'b0;
        mif.mem_d_rstrb = 1'b0;

        test_reset();
        test_fetch();
        test_simultaneous();
        test_conflict();
        test_busy_strobe();
        test_back_to_back();
        test_reset_mid();
`ifdef RV32I_MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding transfers, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
